c2c_slave_ctrl: RTL and testbench
=================================

Name: c2c_slave_ctrl

Overview:
Slave-side Chip2Chip transaction controller. It synchronizes the master's request/valid lines and runs the request -> 1-second notice -> ack -> data -> release handshake. It sequences the 1-second timer through that timer's start/done pair and drives the leftmost notice LED during the wait. Received data is latched for the display path.

Parameters:
DATA_W, 8, width of the inter-chip data bus and latched output.
TIMEOUT_CYCLES, 200000000, maximum cycles spent in WAIT_DATA before abort (2 s at 100 MHz); counter width = $clog2(TIMEOUT_CYCLES+1).

Ports:
clk  input  1  system clock, 100 MHz.
rst  input  1  asynchronous, active-high reset; all flops clear immediately, including synchronizers.
request_in  input  1  master request, asynchronous to clk.
valid_in  input  1  master data-valid, asynchronous to clk.
data_in  input  DATA_W  master data; protocol guarantees it is stable while valid_in=1.
timer_done  input  1  one-cycle pulse from the 1-second timer.
timer_start  output  1  held high to run the timer; low clears the timer.
notice_led  output  1  leftmost LED; high while the 1-second notice runs.
ack  output  1  acknowledge to master.
data_out  output  DATA_W  last successfully received data.
data_pulse  output  1  one-cycle strobe when data_out updates.
err  output  1  sticky timeout flag; cleared by the next accepted request.

Behaviour:
- Synchronizers: request_in and valid_in each pass through 2 flops (req_s, val_s). Internal latency is 2 cycles. data_in is not synchronized; it is sampled only under val_s=1.
- All outputs are registered. Reset values: every output 0, state=IDLE, timeout counter 0.
- States:
  - IDLE: on req_s=1 -> WAIT_SEC; clear err.
  - WAIT_SEC: timer_start=1, notice_led=1.
    - timer_done=1 -> ACK.
    - req_s=0 first -> IDLE (abort); timer_start drops the next cycle.
  - ACK: ack=1; timeout counter runs.
    - val_s=1 -> latch data_in into data_out, data_pulse=1 for one cycle -> HOLD.
    - Counter reaches TIMEOUT_CYCLES-1 without val_s -> err=1, ack=0 -> RELEASE.
    - req_s=0 -> RELEASE without latching.
  - HOLD: ack=1 until val_s=0 and req_s=0 both seen -> IDLE, ack=0.
  - RELEASE: ack=0; wait until req_s=0 and val_s=0 -> IDLE.
- The timeout counter resets on every entry to ACK and holds 0 in all other states.
- timer_done outside WAIT_SEC is ignored.
- val_s=1 before ACK is ignored. A valid that is still high on ACK entry is accepted, because the protocol forbids early valid.
- Simultaneous timer_done and req_s fall in WAIT_SEC: the abort wins -> IDLE, no ack.
- Simultaneous timeout and val_s=1 in ACK: data wins -> HOLD, err stays 0.
- Back-to-back transactions: a new request is recognized only after IDLE is re-entered. A request held high continuously is not re-triggered, because RELEASE/HOLD requires req_s=0.
- Reset mid-transaction:
  - ack, timer_start and notice_led drop asynchronously.
  - data_out clears to 0.
  - The next transaction requires a fresh req_s=1.

Test Plan:
1. Reset, then request_in=1; timer model pulses done 50 cycles after start -> timer_start/notice_led high from cycle 3 after request. ack=1 one cycle after the done pulse.
2. In ACK, data_in=8'hA5 with valid_in=1 -> data_pulse high exactly one cycle and data_out=8'hA5. Drop request/valid -> ack=0 within 3 cycles, state IDLE.
3. TIMEOUT_CYCLES=16, no valid after ack -> err=1 and ack=0 on the 16th ACK cycle. The next request clears err.
4. Drop request_in 10 cycles into WAIT_SEC -> timer_start=0 and notice_led=0 within 3 cycles. ack never asserts, data_pulse never fires.
5. Assert rst asynchronously while in HOLD with data_out=8'h3C -> all outputs 0 immediately, with no clock edge needed.
6. Hold request_in high after a completed transaction -> no second notice/ack until request_in falls and rises again. Same-cycle timer_done and request drop -> no ack.

Source files
------------

// File: rtl/c2c_slave_ctrl_if.sv
// Chip2Chip slave bus: master request/valid/data lines plus the 1-second timer
// start/done pair and the display-side outputs of the slave controller.
interface c2c_slave_ctrl_if #(
  parameter int DATA_W = 8
) ();
  logic              request_in;
  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic              timer_done;
  logic              timer_start;
  logic              notice_led;
  logic              ack;
  logic [DATA_W-1:0] data_out;
  logic              data_pulse;
  logic              err;

  modport slave (
    input  request_in, valid_in, data_in, timer_done,
    output timer_start, notice_led, ack, data_out, data_pulse, err
  );

  modport master (
    output request_in, valid_in, data_in, timer_done,
    input  timer_start, notice_led, ack, data_out, data_pulse, err
  );
endinterface

// File: rtl/c2c_slave_ctrl.sv
// Slave-side Chip2Chip controller: request -> 1 s notice -> ack -> data -> release,
// with a WAIT_DATA timeout that raises a sticky err flag.
module c2c_slave_ctrl #(
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 200000000
) (
  input logic             clk,
  input logic             rst,
  c2c_slave_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WAIT_SEC = 3'd1;
  localparam logic [2:0] ACK      = 3'd2;
  localparam logic [2:0] HOLD     = 3'd3;
  localparam logic [2:0] RELEASE  = 3'd4;

  logic [1:0]        req_sync;
  logic [1:0]        val_sync;
  logic              req_s;
  logic              val_s;
  logic [2:0]        state;
  logic [2:0]        next_state;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              timeout;
  logic [DATA_W-1:0] data_q;

  assign req_s        = req_sync[1];
  assign val_s        = val_sync[1];
  assign bus.data_out = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_sync <= '0;
      val_sync <= '0;
    end else begin
      req_sync <= {req_sync[0], bus.request_in};
      val_sync <= {val_sync[0], bus.valid_in};
    end
  end

  // Abort beats timer_done in WAIT_SEC; data beats both release and timeout in ACK.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE:     if (req_s) next_state = WAIT_SEC;
      WAIT_SEC: begin
        if (!req_s)              next_state = IDLE;
        else if (bus.timer_done) next_state = ACK;
      end
      ACK: begin
        if (val_s) begin
          accept     = 1'b1;
          next_state = HOLD;
        end else if (!req_s) begin
          next_state = RELEASE;
        end else if (cnt == CNT_LAST) begin
          timeout    = 1'b1;
          next_state = RELEASE;
        end
      end
      HOLD:     if (!req_s && !val_s) next_state = IDLE;
      RELEASE:  if (!req_s && !val_s) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state so they change on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.timer_start <= 1'b0;
      bus.notice_led  <= 1'b0;
      bus.ack         <= 1'b0;
      bus.data_pulse  <= 1'b0;
      bus.err         <= 1'b0;
      data_q          <= '0;
    end else begin
      state           <= next_state;
      cnt             <= (state == ACK && next_state == ACK) ? cnt + 1'b1 : '0;
      bus.timer_start <= (next_state == WAIT_SEC);
      bus.notice_led  <= (next_state == WAIT_SEC);
      bus.ack         <= (next_state == ACK) || (next_state == HOLD);
      bus.data_pulse  <= accept;
      if (accept) data_q <= bus.data_in;
      if (state == IDLE && req_s) bus.err <= 1'b0;
      else if (timeout)           bus.err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_c2c_slave_ctrl.sv
// Randomized transaction-level bench for c2c_slave_ctrl; expected event cycles are
// derived from the 2-flop synchronizer latency plus one registered-output edge.
module tb_c2c_slave_ctrl;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;

  c2c_slave_ctrl_if #(.DATA_W(8)) bus ();

  c2c_slave_ctrl #(.DATA_W(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  int cyc = 0;
  int tsRiseCnt, tsRiseCyc, tsFallCyc;
  int ackRiseCnt, ackRiseCyc, ackFallCyc;
  int pulseCnt, pulseCyc;
  logic [7:0] pulseData;
  logic tsPrev = 1'b0;
  logic ackPrev = 1'b0;

  logic       expErr  = 1'b0;
  logic [7:0] expData = 8'h00;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock of observation: record output edges and strobes as cycle stamps.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus.timer_start && !tsPrev) begin tsRiseCnt++; tsRiseCyc = cyc; end
    if (!bus.timer_start && tsPrev) tsFallCyc = cyc;
    if (bus.ack && !ackPrev) begin ackRiseCnt++; ackRiseCyc = cyc; end
    if (!bus.ack && ackPrev) ackFallCyc = cyc;
    if (bus.data_pulse) begin pulseCnt++; pulseCyc = cyc; pulseData = bus.data_out; end
    tsPrev  = bus.timer_start;
    ackPrev = bus.ack;
  endtask

  task automatic clearLog();
    tsRiseCnt = 0;  tsRiseCyc = -1;  tsFallCyc = -1;
    ackRiseCnt = 0; ackRiseCyc = -1; ackFallCyc = -1;
    pulseCnt = 0;   pulseCyc = -1;   pulseData = 8'h00;
  endtask

  // scen: 0 normal, 1 valid before ack, 2 timeout, 3 abort, 4 abort with same-cycle done,
  //       5 request held after data, 6 reset while in HOLD.
  task automatic applyStimulus(input int scen, input logic [7:0] d, input int delay, input int k);
    int R, T, D, A, V, F, expPulse;
    clearLog();
    checkOutput("err_idle", {31'd0, bus.err}, {31'd0, expErr});
    checkOutput("dout_idle", {24'd0, bus.data_out}, {24'd0, expData});

    bus.data_in    = 8'($urandom);
    bus.request_in = 1'b1;
    R = cyc;
    for (int i = 0; i < 10 && !bus.timer_start; i++) tick();
    checkOutput("ts_rise", tsRiseCyc, R + 3);
    checkOutput("notice_on", {31'd0, bus.notice_led}, 32'd1);
    checkOutput("err_clr", {31'd0, bus.err}, 32'd0);
    expErr = 1'b0;
    T = cyc;

    if (scen == 3 || scen == 4) begin
      repeat (k) tick();
      bus.request_in = 1'b0;
      F = cyc;
      if (scen == 4) begin
        tick(); tick();
        bus.timer_done = 1'b1;
        tick();
        bus.timer_done = 1'b0;
      end else begin
        repeat (3) tick();
      end
      checkOutput("ts_abort", tsFallCyc, F + 3);
      checkOutput("notice_off", {31'd0, bus.notice_led}, 32'd0);
      repeat (6) tick();
      checkOutput("abort_noack", ackRiseCnt, 0);
      checkOutput("abort_nopulse", pulseCnt, 0);
      return;
    end

    if (delay < 6) delay = 6;
    repeat (delay - 4) tick();
    V = -100;
    if (scen == 1) begin
      bus.data_in  = d;
      bus.valid_in = 1'b1;
      V = cyc;
    end
    repeat (4) tick();
    D = cyc;
    checkOutput("ack_wait", {31'd0, bus.ack}, 32'd0);
    checkOutput("early_ignored", pulseCnt, 0);
    bus.timer_done = 1'b1;
    tick();
    bus.timer_done = 1'b0;
    A = cyc;
    checkOutput("ack_rise", ackRiseCyc, D + 1);
    checkOutput("ts_drop", {31'd0, bus.timer_start}, 32'd0);

    if (scen == 2) begin
      repeat (TO) tick();
      checkOutput("to_ackfall", ackFallCyc, A + TO);
      checkOutput("to_err", {31'd0, bus.err}, 32'd1);
      expErr = 1'b1;
      repeat (10) tick();
      checkOutput("to_noretrig", tsRiseCnt, 1);
      bus.request_in = 1'b0;
      repeat (4) tick();
      checkOutput("to_nopulse", pulseCnt, 0);
      return;
    end

    if (scen != 1) begin
      repeat (k) tick();
      bus.data_in  = d;
      bus.valid_in = 1'b1;
      V = cyc;
    end
    expPulse = (A + 1 > V + 3) ? A + 1 : V + 3;
    for (int i = 0; i < 15 && pulseCnt == 0; i++) tick();
    checkOutput("pulse_cyc", pulseCyc, expPulse);
    checkOutput("pulse_data", {24'd0, pulseData}, {24'd0, d});
    tick(); tick();
    checkOutput("pulse_once", pulseCnt, 1);
    checkOutput("dout_hold", {24'd0, bus.data_out}, {24'd0, d});
    checkOutput("ack_hold", {31'd0, bus.ack}, 32'd1);
    expData = d;

    if (scen == 6) begin
      #2 rst = 1'b1;
      #1;
      checkOutput("rst_ack", {31'd0, bus.ack}, 32'd0);
      checkOutput("rst_dout", {24'd0, bus.data_out}, 32'd0);
      checkOutput("rst_ts", {30'd0, bus.timer_start, bus.notice_led}, 32'd0);
      checkOutput("rst_err_pulse", {30'd0, bus.err, bus.data_pulse}, 32'd0);
      bus.request_in = 1'b0;
      bus.valid_in   = 1'b0;
      tick();
      rst = 1'b0;
      expData = 8'h00;
      expErr  = 1'b0;
      repeat (3) tick();
      return;
    end

    if (scen == 5) begin
      bus.valid_in = 1'b0;
      repeat (15) tick();
      checkOutput("held_noretrig", tsRiseCnt, 1);
      checkOutput("held_ack", {31'd0, bus.ack}, 32'd1);
    end

    bus.request_in = 1'b0;
    bus.valid_in   = 1'b0;
    F = cyc;
    bus.data_in = 8'($urandom);
    repeat (3) tick();
    checkOutput("ack_release", ackFallCyc, F + 3);
    repeat (2) tick();
  endtask

  initial begin
    rst            = 1'b1;
    bus.request_in = 1'b0;
    bus.valid_in   = 1'b0;
    bus.data_in    = 8'h00;
    bus.timer_done = 1'b0;
    clearLog();
    repeat (3) tick();
    checkOutput("reset_ack", {31'd0, bus.ack}, 32'd0);
    checkOutput("reset_ts", {30'd0, bus.timer_start, bus.notice_led}, 32'd0);
    checkOutput("reset_dout", {24'd0, bus.data_out}, 32'd0);
    checkOutput("reset_err_pulse", {30'd0, bus.err, bus.data_pulse}, 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    applyStimulus(0, 8'hA5, 50, 0);
    applyStimulus(2, 8'h00, 20, 0);
    applyStimulus(0, 8'h5A, 12, 2);
    applyStimulus(3, 8'h00, 0, 10);
    applyStimulus(6, 8'h3C, 10, 1);
    applyStimulus(5, 8'hC3, 8, 3);
    applyStimulus(4, 8'h00, 0, 5);
    applyStimulus(1, 8'h96, 12, 0);

    for (int n = 0; n < 25; n++) begin
      int scen;
      scen = int'($urandom_range(0, 6));
      if (scen == 3 || scen == 4)
        applyStimulus(scen, 8'h00, 0, int'($urandom_range(1, 20)));
      else
        applyStimulus(scen, 8'($urandom), int'($urandom_range(6, 60)), int'($urandom_range(0, 5)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
